// File: rtl/sfx_pkg.sv
// Shared types, constants and table contents for the sound-effect sequencer.
// Table entries are returned 32 bits wide and truncated to DIV_W by the ROM.
package sfx_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_e;

  localparam logic [31:0] NOTE_REST = 32'h0000_0000;
  localparam logic [31:0] NOTE_END  = 32'hFFFF_FFFF;

  // Half-periods minus one at a 50 MHz clock.
  localparam logic [31:0] C5_HALF = 32'd47777;
  localparam logic [31:0] G5_HALF = 32'd31887;

  localparam logic [15:0] SAMPLE_LOW = 16'h2000;

  localparam int TABLE_GAME    = 0;
  localparam int TABLE_BRINGUP = 1;

  function automatic logic [15:0] amp(input logic [2:0] vol);
    case (vol)
      3'd0:    amp = 16'h2000;
      3'd1:    amp = 16'h20A0;
      3'd2:    amp = 16'h2300;
      3'd3:    amp = 16'h2A00;
      3'd4:    amp = 16'h3000;
      default: amp = 16'h4000;
    endcase
  endfunction

  // Anything not listed reads as END, so short effects need no padding.
  function automatic logic [31:0] table_entry(input int set, input int id, input int step);
    table_entry = NOTE_END;
    if (set == TABLE_GAME) begin
      case (id)
        0: begin // jump
          if (step == 0)                 table_entry = C5_HALF;
          else if (step >= 1 && step <= 3) table_entry = G5_HALF;
        end
        1: begin // score
          if (step >= 0 && step <= 3) table_entry = C5_HALF;
        end
        default: table_entry = NOTE_END;
      endcase
    end else begin
      case (id)
        1: begin
          if (step == 0 || step == 1) table_entry = 32'd3;
          else if (step == 2)         table_entry = NOTE_REST;
        end
        2: begin
          if (step >= 0 && step <= 3) table_entry = 32'd1;
        end
        3: begin
          if (step == 0) table_entry = 32'd2;
        end
        default: table_entry = NOTE_END;
      endcase
    end
  endfunction

endpackage

// File: rtl/sfx_rom.sv
// Combinational note table: (effect id, step) -> DIV_W-bit entry.
module sfx_rom
  import sfx_pkg::*;
#(
  parameter int DIV_W     = 22,
  parameter int ID_W      = 2,
  parameter int STEP_W    = 3,
  parameter int TABLE_SET = TABLE_GAME
) (
  input  logic [ID_W-1:0]   id_i,
  input  logic [STEP_W-1:0] step_i,
  output logic [DIV_W-1:0]  entry_o
);

  always_comb begin
    entry_o = DIV_W'(table_entry(TABLE_SET, int'(id_i), int'(step_i)));
  end

endmodule

// File: rtl/sfx_sequencer.sv
// Priority-resolved sound-effect player: steps a per-effect note table at a
// fixed tick rate and emits a registered square-wave sample.
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int NUM_SFX   = 4,
  parameter int STEPS     = 8,
  parameter int TICK_DIV  = 12_500_000,
  parameter int DIV_W     = 22,
  parameter int TABLE_SET = TABLE_GAME,
  localparam int ID_W     = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1,
  localparam int STEP_W   = (STEPS > 1) ? $clog2(STEPS) : 1,
  localparam int TICK_W   = $clog2(TICK_DIV)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SFX-1:0] trig,
  input  logic [2:0]         vol,
  input  logic               mute,
  output logic               busy,
  output logic               done,
  output logic [ID_W-1:0]    sfx_id,
  output logic [DIV_W-1:0]   note_div,
  output logic [15:0]        audio
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [2:0]          vol_q, vol_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [DIV_W-1:0]    half_q, half_d;
  logic                phase_q, phase_d;
  logic [DIV_W-1:0]    note_q, note_d;
  logic [15:0]         audio_q, audio_d;
  logic                done_q, done_d;

  logic [ID_W-1:0]     win_id;
  logic                accept, tick_term, last_step, nat_end;
  logic [DIV_W-1:0]    entry_cur, entry_nxt;
  logic                cur_silent;

  sfx_rom #(.DIV_W(DIV_W), .ID_W(ID_W), .STEP_W(STEP_W), .TABLE_SET(TABLE_SET)) u_rom_cur (
    .id_i   (id_q),
    .step_i (step_q),
    .entry_o(entry_cur)
  );

  sfx_rom #(.DIV_W(DIV_W), .ID_W(ID_W), .STEP_W(STEP_W), .TABLE_SET(TABLE_SET)) u_rom_nxt (
    .id_i   (id_q),
    .step_i (step_q + STEP_W'(1)),
    .entry_o(entry_nxt)
  );

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_SFX; i++) begin
      if (trig[i]) win_id = ID_W'(i);
    end
  end

  // A lower id is dropped while playing; equal id restarts the effect.
  assign accept     = (|trig) && (state_q == S_IDLE || win_id >= id_q);
  assign tick_term  = (tick_q == TICK_W'(TICK_DIV - 1));
  assign last_step  = (step_q == STEP_W'(STEPS - 1)) || (entry_nxt == '1) || (entry_cur == '1);
  assign nat_end    = (state_q == S_PLAY) && tick_term && last_step;
  assign cur_silent = (entry_cur == '0) || (entry_cur == '1);

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_PLAY;
      S_PLAY:  if (!accept && nat_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_PLAY);
    done = done_q;
  end

  always_comb begin
    id_d    = id_q;
    vol_d   = vol_q;
    step_d  = step_q;
    tick_d  = tick_q;
    half_d  = half_q;
    phase_d = phase_q;
    if (accept) begin
      id_d    = win_id;
      vol_d   = vol;
      step_d  = '0;
      tick_d  = '0;
      half_d  = '0;
      phase_d = 1'b0;
    end else if (state_q == S_PLAY) begin
      if (tick_term) begin
        tick_d  = '0;
        step_d  = last_step ? '0 : step_q + STEP_W'(1);
        half_d  = '0;
        phase_d = 1'b0;
      end else begin
        tick_d = tick_q + TICK_W'(1);
        if (half_q == note_q) begin
          half_d  = '0;
          phase_d = ~phase_q;
        end else begin
          half_d = half_q + DIV_W'(1);
        end
      end
    end
  end

  always_comb begin
    done_d  = nat_end && !accept;
    note_d  = (state_q == S_PLAY && (accept || !nat_end)) ? entry_cur : '0;
    audio_d = '0;
    if (state_q == S_PLAY && !mute && !cur_silent) begin
      audio_d = phase_q ? SAMPLE_LOW : amp(vol_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q    <= '0;
      vol_q   <= '0;
      step_q  <= '0;
      tick_q  <= '0;
      half_q  <= '0;
      phase_q <= 1'b0;
      note_q  <= '0;
      audio_q <= '0;
      done_q  <= 1'b0;
    end else begin
      id_q    <= id_d;
      vol_q   <= vol_d;
      step_q  <= step_d;
      tick_q  <= tick_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      note_q  <= note_d;
      audio_q <= audio_d;
      done_q  <= done_d;
    end
  end

  assign sfx_id   = id_q;
  assign note_div = note_q;
  assign audio    = audio_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer using the small bring-up note table.
module tb_sfx_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  trig;
  logic [2:0]  vol;
  logic        mute;
  logic        busy, done;
  logic [1:0]  sfx_id;
  logic [21:0] note_div;
  logic [15:0] audio;

  int checks = 0;
  int errors = 0;

  sfx_sequencer #(
    .NUM_SFX  (4),
    .STEPS    (4),
    .TICK_DIV (4),
    .DIV_W    (22),
    .TABLE_SET(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .trig    (trig),
    .vol     (vol),
    .mute    (mute),
    .busy    (busy),
    .done    (done),
    .sfx_id  (sfx_id),
    .note_div(note_div),
    .audio   (audio)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int busy_total = 0, done_total = 0, nz_total = 0, last_done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_total <= busy_total + 1;
    if (done === 1'b1) begin
      done_total    <= done_total + 1;
      last_done_cyc <= cyc;
    end
    if (audio !== 16'h0000) nz_total <= nz_total + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic [3:0] t, input logic [2:0] v);
    trig = t;
    vol  = v;
    wait_cyc(1);
    trig = 4'b0000;
  endtask

  typedef struct {
    logic [3:0]  trig;
    logic [2:0]  vol;
    logic        mute;
    logic        busy;
    logic        done;
    logic [1:0]  id;
    logic [21:0] nd;
    logic [15:0] audio;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] t, input logic [2:0] v, input logic m,
                              input logic b, input logic d, input logic [1:0] id,
                              input logic [21:0] nd, input logic [15:0] a);
    mk.trig = t; mk.vol = v; mk.mute = m;
    mk.busy = b; mk.done = d; mk.id = id; mk.nd = nd; mk.audio = a;
  endfunction

  vec_t vecs [15];

  int t0, b0, d0, n0;

  initial begin
    // Effect 1 = {3,3,rest,END}: vol captured at 4, later vol=7 must be ignored.
    vecs[0]  = mk(4'b0010, 3'd4, 1'b0, 1'b0, 1'b0, 2'd0, 22'd0, 16'h0000);
    vecs[1]  = mk(4'b0000, 3'd7, 1'b0, 1'b1, 1'b0, 2'd1, 22'd0, 16'h0000);
    vecs[2]  = mk(4'b0000, 3'd7, 1'b0, 1'b1, 1'b0, 2'd1, 22'd3, 16'h3000);
    vecs[3]  = mk(4'b0000, 3'd7, 1'b0, 1'b1, 1'b0, 2'd1, 22'd3, 16'h2000);
    vecs[4]  = mk(4'b0000, 3'd7, 1'b0, 1'b1, 1'b0, 2'd1, 22'd3, 16'h2000);
    vecs[5]  = mk(4'b0000, 3'd7, 1'b0, 1'b1, 1'b0, 2'd1, 22'd3, 16'h2000);
    vecs[6]  = mk(4'b0000, 3'd7, 1'b0, 1'b1, 1'b0, 2'd1, 22'd3, 16'h3000);
    vecs[7]  = mk(4'b0000, 3'd7, 1'b0, 1'b1, 1'b0, 2'd1, 22'd3, 16'h3000);
    vecs[8]  = mk(4'b0000, 3'd7, 1'b0, 1'b1, 1'b0, 2'd1, 22'd3, 16'h3000);
    vecs[9]  = mk(4'b0000, 3'd7, 1'b0, 1'b1, 1'b0, 2'd1, 22'd3, 16'h3000);
    vecs[10] = mk(4'b0000, 3'd7, 1'b0, 1'b1, 1'b0, 2'd1, 22'd0, 16'h0000);
    vecs[11] = mk(4'b0000, 3'd7, 1'b0, 1'b1, 1'b0, 2'd1, 22'd0, 16'h0000);
    vecs[12] = mk(4'b0000, 3'd7, 1'b0, 1'b1, 1'b0, 2'd1, 22'd0, 16'h0000);
    vecs[13] = mk(4'b0000, 3'd7, 1'b0, 1'b0, 1'b1, 2'd1, 22'd0, 16'h0000);
    vecs[14] = mk(4'b0000, 3'd7, 1'b0, 1'b0, 1'b0, 2'd1, 22'd0, 16'h0000);

    rst  = 1'b1;
    trig = 4'b0000;
    vol  = 3'd0;
    mute = 1'b0;
    wait_cyc(2);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset sfx_id", 32'(sfx_id), 32'd0);
    check("reset note_div", 32'(note_div), 32'd0);
    check("reset audio", 32'(audio), 32'd0);
    rst = 1'b0;
    wait_cyc(1);

    for (int i = 0; i < 15; i++) begin
      trig = vecs[i].trig;
      vol  = vecs[i].vol;
      mute = vecs[i].mute;
      @(negedge clk);
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].done));
      check($sformatf("v%0d sfx_id", i), 32'(sfx_id), 32'(vecs[i].id));
      check($sformatf("v%0d note_div", i), 32'(note_div), 32'(vecs[i].nd));
      check($sformatf("v%0d audio", i), 32'(audio), 32'(vecs[i].audio));
      @(posedge clk);
      #1;
    end
    trig = 4'b0000;
    wait_cyc(2);

    // Effect 0 is END at step 0: one silent tick, then done.
    t0 = cyc; b0 = busy_total; d0 = done_total; n0 = nz_total;
    fire(4'b0001, 3'd7);
    wait_cyc(7);
    check("end0 busy cycles", 32'(busy_total - b0), 32'd4);
    check("end0 done count", 32'(done_total - d0), 32'd1);
    check("end0 done cycle", 32'(last_done_cyc - t0), 32'd5);
    check("end0 silent", 32'(nz_total - n0), 32'd0);

    // Multiple bits from idle: highest id wins.
    fire(4'b1010, 3'd1);
    check("prio sfx_id", 32'(sfx_id), 32'd3);
    check("prio busy", 32'(busy), 32'd1);
    wait_cyc(8);

    // Lower-id trigger during effect 2 is ignored.
    t0 = cyc; b0 = busy_total; d0 = done_total;
    fire(4'b0100, 3'd3);
    wait_cyc(5);
    fire(4'b0010, 3'd3);
    check("ignore sfx_id", 32'(sfx_id), 32'd2);
    wait_cyc(13);
    check("ignore busy cycles", 32'(busy_total - b0), 32'd16);
    check("ignore done count", 32'(done_total - d0), 32'd1);
    check("ignore done cycle", 32'(last_done_cyc - t0), 32'd17);

    // Effect 3 preempts effect 1 at step 1; only effect 3 reports done.
    t0 = cyc; d0 = done_total;
    fire(4'b0010, 3'd0);
    wait_cyc(4);
    fire(4'b1000, 3'd2);
    check("preempt sfx_id", 32'(sfx_id), 32'd3);
    check("preempt busy", 32'(busy), 32'd1);
    wait_cyc(1);
    check("preempt audio", 32'(audio), 32'h2300);
    check("preempt note_div", 32'(note_div), 32'd2);
    wait_cyc(3);
    check("preempt end busy", 32'(busy), 32'd0);
    check("preempt end done", 32'(done), 32'd1);
    check("preempt end audio", 32'(audio), 32'h2000);
    wait_cyc(1);
    check("preempt silent", 32'(audio), 32'd0);
    wait_cyc(3);
    check("preempt done count", 32'(done_total - d0), 32'd1);
    check("preempt done cycle", 32'(last_done_cyc - t0), 32'd10);

    // Restart on the final tick: accept beats natural end.
    t0 = cyc; b0 = busy_total; d0 = done_total;
    fire(4'b0100, 3'd1);
    wait_cyc(15);
    fire(4'b0100, 3'd1);
    check("restart no done", 32'(done), 32'd0);
    check("restart busy", 32'(busy), 32'd1);
    wait_cyc(16);
    check("restart end done", 32'(done), 32'd1);
    check("restart end busy", 32'(busy), 32'd0);
    wait_cyc(1);
    check("restart busy cycles", 32'(busy_total - b0), 32'd32);
    check("restart done count", 32'(done_total - d0), 32'd1);
    check("restart done cycle", 32'(last_done_cyc - t0), 32'd33);

    // Muted effect: silent output, unchanged sequencing.
    t0 = cyc; b0 = busy_total; d0 = done_total; n0 = nz_total;
    mute = 1'b1;
    fire(4'b0100, 3'd7);
    wait_cyc(18);
    mute = 1'b0;
    check("mute busy cycles", 32'(busy_total - b0), 32'd16);
    check("mute done count", 32'(done_total - d0), 32'd1);
    check("mute done cycle", 32'(last_done_cyc - t0), 32'd17);
    check("mute silent", 32'(nz_total - n0), 32'd0);

    // Asynchronous reset in the middle of a tone.
    fire(4'b0100, 3'd5);
    wait_cyc(1);
    check("pre-reset audio", 32'(audio), 32'h4000);
    wait_cyc(1);
    rst = 1'b1;
    #1;
    check("async rst audio", 32'(audio), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst sfx_id", 32'(sfx_id), 32'd0);
    check("async rst note_div", 32'(note_div), 32'd0);
    wait_cyc(2);
    rst = 1'b0;
    b0 = busy_total; d0 = done_total; n0 = nz_total;
    wait_cyc(6);
    check("post-rst busy cycles", 32'(busy_total - b0), 32'd0);
    check("post-rst done count", 32'(done_total - d0), 32'd0);
    check("post-rst audio count", 32'(nz_total - n0), 32'd0);
    check("post-rst note_div", 32'(note_div), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
